// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: receive side of one TMDS channel.
// Finds word alignment from control-token runs (requesting SERDES bitslips
// while searching). Decodes each symbol into pixel data or a control code.
// Optional feature macro: TMDS_LOSS_CNT_EN adds a saturating loss_count output.
module tmds_channel_decoder #(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out
`ifdef TMDS_LOSS_CNT_EN
    ,
    output logic [15:0] loss_count
`endif
);

    localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
    localparam int TMR_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
    localparam int GAP_W  = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Returns {hit, code} for the four control tokens (MSB-first symbols).
    function automatic logic [2:0] token_match(input logic [9:0] sym);
        logic [2:0] r;
        case (sym)
            10'b1101010100: r = 3'b1_00;
            10'b0010101011: r = 3'b1_01;
            10'b0101010100: r = 3'b1_10;
            10'b1010101011: r = 3'b1_11;
            default:        r = 3'b0_00;
        endcase
        return r;
    endfunction

    // Undo the TMDS inversion stage, then the XOR/XNOR transition chain.
    function automatic logic [7:0] decode_data(input logic [9:0] sym);
        logic [7:0] d;
        logic [7:0] q;
        d    = sym[9] ? ~sym[7:0] : sym[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    logic [2:0]        match_in;
    logic              tok_in;
    logic [1:0]        code_in;

    logic [9:0]        sym_p1;
    logic              tok_p1;
    logic [1:0]        code_p1;
    logic              vld_p1;

    state_t            state, state_n;
    logic [RUN_W-1:0]  run, run_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic [SLIP_W-1:0] slip_cnt, slip_cnt_n;
    logic [GAP_W-1:0]  gap, gap_n;
    logic              bitslip_n;

    assign match_in = token_match(sym_in);
    assign tok_in   = match_in[2];
    assign code_in  = match_in[1:0];
    assign aligned  = (state == LOCKED);

    // Stage 1: capture the raw symbol with its token classification.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            sym_p1  <= '0;
            tok_p1  <= 1'b0;
            code_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            sym_p1  <= sym_in;
            tok_p1  <= tok_in;
            code_p1 <= code_in;
            vld_p1  <= 1'b1;
        end
    end

    // Stage 2: decoded outputs; the field not being updated holds its value.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            de       <= 1'b0;
            data_out <= '0;
            ctrl_out <= '0;
        end else if (vld_p1) begin
            if (tok_p1) begin
                de       <= 1'b0;
                ctrl_out <= code_p1;
            end else begin
                de       <= 1'b1;
                data_out <= decode_data(sym_p1);
            end
        end
    end

    // Alignment FSM state and counter registers.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            state    <= SEARCH;
            run      <= '0;
            timer    <= '0;
            slip_cnt <= '0;
            gap      <= '0;
            bitslip  <= 1'b0;
        end else begin
            state    <= state_n;
            run      <= run_n;
            timer    <= timer_n;
            slip_cnt <= slip_cnt_n;
            gap      <= gap_n;
            bitslip  <= bitslip_n;
        end
    end

    // Alignment FSM next-state: lock beats a simultaneous search timeout.
    always_comb begin
        state_n    = state;
        run_n      = run;
        timer_n    = timer;
        slip_cnt_n = slip_cnt;
        gap_n      = gap;
        bitslip_n  = 1'b0;
        case (state)
            SEARCH: begin
                if (tok_in && (run == RUN_LAST)) begin
                    state_n = LOCKED;
                    run_n   = '0;
                    timer_n = '0;
                    gap_n   = '0;
                end else if (timer == TMR_LAST) begin
                    state_n    = SLIP;
                    bitslip_n  = 1'b1;
                    run_n      = '0;
                    timer_n    = '0;
                    slip_cnt_n = '0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                    run_n   = tok_in ? (run + RUN_W'(1)) : '0;
                end
            end
            SLIP: begin
                run_n = '0;
                if (slip_cnt == SLIP_LAST) begin
                    state_n    = SEARCH;
                    timer_n    = '0;
                    slip_cnt_n = '0;
                end else begin
                    slip_cnt_n = slip_cnt + SLIP_W'(1);
                end
            end
            LOCKED: begin
                if (tok_in) begin
                    gap_n = '0;
                end else if (gap == GAP_LAST) begin
                    state_n = SEARCH;
                    timer_n = '0;
                    run_n   = '0;
                    gap_n   = '0;
                end else begin
                    gap_n = gap + GAP_W'(1);
                end
            end
            default: begin
                state_n = SEARCH;
                run_n   = '0;
                timer_n = '0;
                gap_n   = '0;
            end
        endcase
    end

`ifdef TMDS_LOSS_CNT_EN
    logic lost;
    assign lost = (state == LOCKED) && (state_n == SEARCH);

    // Saturating count of lock losses.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            loss_count <= '0;
        end else if (lost && (loss_count != 16'hFFFF)) begin
            loss_count <= loss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: a TMDS encoder model produces
// data symbols whose expected decode is simply the original byte.
module tb_tmds_channel_decoder;

    localparam int TR = 8;
    localparam int ST = 64;
    localparam int SW = 16;
    localparam int LT = 200;

    logic       pixclk = 1'b0;
    logic       rst    = 1'b1;
    logic [9:0] sym_in = '0;
    logic       bitslip, aligned, de;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
`ifdef TMDS_LOSS_CNT_EN
    logic [15:0] loss_count;
`endif

    tmds_channel_decoder #(
        .TOKEN_RUN(TR), .SEARCH_TIMEOUT(ST), .SLIP_WAIT(SW), .LOSS_TIMEOUT(LT)
    ) dut (
        .pixclk(pixclk), .rst(rst), .sym_in(sym_in), .bitslip(bitslip),
        .aligned(aligned), .de(de), .data_out(data_out), .ctrl_out(ctrl_out)
`ifdef TMDS_LOSS_CNT_EN
        , .loss_count(loss_count)
`endif
    );

    always #5 pixclk = ~pixclk;

    int checks = 0;
    int passes = 0;

    // reference model: current expected outputs plus the symbol in flight
    logic       exp_de, pend_vld, pend_tok;
    logic [7:0] exp_data, pend_byte;
    logic [1:0] exp_ctrl, pend_code;
    int         disp;
    int         exp_loss;

    function automatic logic [9:0] tok_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] x, input int k);
        logic [19:0] t;
        t = {x, x};
        return t[19-k -: 10];
    endfunction

    // DVI/HDMI TMDS 8b/10b data encoder with running disparity.
    task automatic encode(input logic [7:0] b, output logic [9:0] s);
        logic [8:0] qm;
        int n1d, n1, n0, q8;
        n1d = $countones(b);
        qm[0] = b[0];
        if (n1d > 4 || (n1d == 4 && b[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        q8 = qm[8] ? 1 : 0;
        if (disp == 0 || n1 == n0) begin
            s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp = (q8 == 0) ? disp + n0 - n1 : disp + n1 - n0;
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + 2 * q8 + n0 - n1;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            disp = disp - 2 * (1 - q8) + n1 - n0;
        end
    endtask

    task automatic model_clear();
        exp_de = 0; exp_data = 0; exp_ctrl = 0;
        pend_vld = 0; pend_tok = 0; pend_byte = 0; pend_code = 0;
        disp = 0; exp_loss = 0;
    endtask

    // Drive one symbol for one clock; the model's expected outputs are what
    // the symbol sent one call earlier means (2-cycle latency overall).
    task automatic clk_step(input logic [9:0] s, input logic is_tok,
                            input logic [1:0] code, input logic [7:0] byt);
        sym_in = s;
        @(posedge pixclk);
        #1;
        if (pend_vld) begin
            if (pend_tok) begin exp_de = 0; exp_ctrl = pend_code; end
            else begin exp_de = 1; exp_data = pend_byte; end
        end
        pend_vld = 1; pend_tok = is_tok; pend_code = code; pend_byte = byt;
    endtask

    task automatic send_token(input logic [1:0] c);
        clk_step(tok_sym(c), 1'b1, c, 8'h00);
    endtask

    task automatic send_data(input logic [7:0] b);
        logic [9:0] s;
        encode(b, s);
        clk_step(s, 1'b0, 2'b00, b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sym_in = '0;
        repeat (2) @(posedge pixclk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (aligned !== 1'b0) $display("FAIL reset_aligned got %b want 0", aligned); else passes++;
        checks++; if (bitslip !== 1'b0) $display("FAIL reset_bitslip got %b want 0", bitslip); else passes++;
        checks++;
        if ({de, data_out, ctrl_out} !== 11'd0)
            $display("FAIL reset_outputs got de=%b data=%h ctrl=%b want all 0", de, data_out, ctrl_out);
        else passes++;
`ifdef TMDS_LOSS_CNT_EN
        checks++; if (loss_count !== 16'd0) $display("FAIL reset_loss_count got %0d want 0", loss_count); else passes++;
`endif
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 1; i <= TR + 2; i++) begin
            send_token(2'b00);
            checks++;
            if (aligned !== (i >= TR)) $display("FAIL lock_aligned step %0d got %b want %b", i, aligned, (i >= TR));
            else passes++;
            checks++;
            if (bitslip !== 1'b0) $display("FAIL lock_bitslip step %0d got %b want 0", i, bitslip); else passes++;
            checks++;
            if ({de, data_out, ctrl_out} !== {exp_de, exp_data, exp_ctrl})
                $display("FAIL lock_out step %0d got %b/%h/%b want %b/%h/%b", i, de, data_out, ctrl_out, exp_de, exp_data, exp_ctrl);
            else passes++;
        end
    endtask

    task automatic test_decode();
        int order [256];
        int since_tok;
        do_reset();
        for (int i = 0; i < TR; i++) send_token(2'b00);
        clk_step(10'b0100000000, 1'b0, 2'b00, 8'h00);
        clk_step(10'b1000000000, 1'b0, 2'b00, 8'hFF);
        checks++;
        if (de !== 1'b1 || data_out !== 8'h00) $display("FAIL decode_0100000000 got de=%b data=%h want 1/00", de, data_out);
        else passes++;
        send_token(2'b11);
        checks++;
        if (de !== 1'b1 || data_out !== 8'hFF) $display("FAIL decode_1000000000 got de=%b data=%h want 1/ff", de, data_out);
        else passes++;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        since_tok = 0;
        for (int i = 0; i < 258; i++) begin
            if (i < 256 && ($urandom_range(0, 7) == 0 || since_tok > 50)) begin
                send_token(2'($urandom_range(0, 3)));
                since_tok = 0;
                checks++;
                if ({de, data_out, ctrl_out} !== {exp_de, exp_data, exp_ctrl})
                    $display("FAIL decode_tok got %b/%h/%b want %b/%h/%b", de, data_out, ctrl_out, exp_de, exp_data, exp_ctrl);
                else passes++;
            end
            if (i < 256) begin send_data(8'(order[i])); since_tok++; end
            else send_token(2'b10);
            checks++;
            if ({de, data_out, ctrl_out} !== {exp_de, exp_data, exp_ctrl})
                $display("FAIL decode_sweep %0d got %b/%h/%b want %b/%h/%b", i, de, data_out, ctrl_out, exp_de, exp_data, exp_ctrl);
            else passes++;
            checks++;
            if (aligned !== 1'b1) $display("FAIL decode_aligned %0d got %b want 1", i, aligned); else passes++;
        end
    endtask

    task automatic test_broken_run();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < TR - 1; i++) begin
                send_token(2'b01);
                checks++;
                if (aligned !== 1'b0) $display("FAIL broken_aligned got %b want 0", aligned); else passes++;
            end
            send_data(8'($urandom));
            checks++;
            if (aligned !== 1'b0) $display("FAIL broken_aligned_data got %b want 0", aligned); else passes++;
        end
        for (int i = 1; i <= TR; i++) begin
            send_token(2'b01);
            checks++;
            if (aligned !== (i == TR)) $display("FAIL broken_relock step %0d got %b want %b", i, aligned, (i == TR));
            else passes++;
            checks++;
            if ({de, data_out, ctrl_out} !== {exp_de, exp_data, exp_ctrl})
                $display("FAIL broken_out got %b/%h/%b want %b/%h/%b", de, data_out, ctrl_out, exp_de, exp_data, exp_ctrl);
            else passes++;
        end
    endtask

    task automatic test_lock_beats_timeout();
        int slips;
        do_reset();
        slips = 0;
        for (int i = 1; i <= ST - TR; i++) begin
            send_data(8'($urandom));
            if (bitslip === 1'b1) slips++;
        end
        for (int i = 1; i <= TR; i++) begin
            send_token(2'b00);
            if (bitslip === 1'b1) slips++;
        end
        checks++;
        if (aligned !== 1'b1) $display("FAIL tie_aligned got %b want 1", aligned); else passes++;
        send_token(2'b00);
        if (bitslip === 1'b1) slips++;
        checks++;
        if (slips !== 0) $display("FAIL tie_bitslip got %0d pulses want 0", slips); else passes++;
    endtask

    task automatic test_misaligned();
        int off, slips, first_lock, bad, budget;
        int slip_at [3];
        do_reset();
        off = 3; slips = 0; first_lock = 0; bad = 0;
        slip_at[0] = 0; slip_at[1] = 0; slip_at[2] = 0;
        budget = 4 * ST + 4 * SW + 40;
        for (int c = 1; c <= budget; c++) begin
            clk_step(rotl(tok_sym(2'b00), off), 1'b0, 2'b00, 8'h00);
            if (bitslip === 1'b1) begin
                if (aligned === 1'b1) bad++;
                if (slips < 3) slip_at[slips] = c;
                slips++;
                off = (off + 9) % 10;
            end
            if (aligned === 1'b1 && first_lock == 0) first_lock = c;
            if (first_lock != 0 && c > first_lock + 4) break;
        end
        checks++; if (slip_at[0] !== ST) $display("FAIL slip1_cycle got %0d want %0d", slip_at[0], ST); else passes++;
        checks++; if (slip_at[1] !== 2*ST+SW) $display("FAIL slip2_cycle got %0d want %0d", slip_at[1], 2*ST+SW); else passes++;
        checks++; if (slip_at[2] !== 3*ST+2*SW) $display("FAIL slip3_cycle got %0d want %0d", slip_at[2], 3*ST+2*SW); else passes++;
        checks++; if (slips !== 3) $display("FAIL slip_count got %0d want 3", slips); else passes++;
        checks++;
        if (first_lock !== 3*ST+3*SW+TR) $display("FAIL misaligned_lock_cycle got %0d want %0d", first_lock, 3*ST+3*SW+TR);
        else passes++;
        checks++; if (bad !== 0) $display("FAIL slip_while_locked got %0d want 0", bad); else passes++;
    endtask

    task automatic test_loss();
        do_reset();
        for (int r = 1; r <= 2; r++) begin
            for (int i = 0; i < TR; i++) send_token(2'b10);
            checks++;
            if (aligned !== 1'b1) $display("FAIL loss_lock%0d got %b want 1", r, aligned); else passes++;
            for (int n = 1; n <= LT; n++) begin
                send_data(8'($urandom));
                checks++;
                if (aligned !== (n < LT)) $display("FAIL loss_aligned run %0d n %0d got %b want %b", r, n, aligned, (n < LT));
                else passes++;
                checks++;
                if ({de, data_out, ctrl_out} !== {exp_de, exp_data, exp_ctrl})
                    $display("FAIL loss_out n %0d got %b/%h/%b want %b/%h/%b", n, de, data_out, ctrl_out, exp_de, exp_data, exp_ctrl);
                else passes++;
            end
            exp_loss++;
`ifdef TMDS_LOSS_CNT_EN
            checks++;
            if (loss_count !== 16'(exp_loss)) $display("FAIL loss_count got %0d want %0d", loss_count, exp_loss);
            else passes++;
`endif
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        for (int i = 0; i < TR; i++) send_token(2'b11);
        for (int i = 0; i < 5; i++) send_data(8'($urandom));
        checks++;
        if (aligned !== 1'b1 || de !== 1'b1) $display("FAIL midrst_pre got aligned=%b de=%b want 1/1", aligned, de);
        else passes++;
        rst = 1'b1;
        @(posedge pixclk);
        #1;
        checks++; if (aligned !== 1'b0) $display("FAIL midrst_aligned got %b want 0", aligned); else passes++;
        checks++;
        if ({de, data_out, ctrl_out} !== 11'd0)
            $display("FAIL midrst_outputs got de=%b data=%h ctrl=%b want all 0", de, data_out, ctrl_out);
        else passes++;
        @(posedge pixclk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int i = 1; i <= TR; i++) begin
            send_token(2'b11);
            checks++;
            if (aligned !== (i == TR)) $display("FAIL midrst_relock step %0d got %b want %b", i, aligned, (i == TR));
            else passes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_clear();
        test_reset();
        test_lock();
        test_decode();
        test_broken_run();
        test_lock_beats_timeout();
        test_misaligned();
        test_loss();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
